nibble_sub_seq: RTL and testbench

- Sequential multi-nibble subtractor: computes diff = a_in - b_in - bi over WIDTH bits, one 4-bit lookahead-borrow slice per clock.
- Arithmetic counterpart to the team's 4-bit carry-lookahead adder.
- Operands enter through a valid/ready handshake. The result leaves through a second valid/ready handshake.
- Used wherever the datapath needs a wide subtract/compare with a small area budget.

---
 rtl/nibble_sub_seq.sv | 115 +++++++++++
 tb/tb_nibble_sub_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_sub_seq.sv
// Sequential WIDTH-bit subtractor: diff = a_in - b_in - bi, one lookahead-borrow nibble per clock.
// Optional signed-overflow output enabled by defining NIBBLE_SUB_OVF_EN.
module nibble_sub_seq #(
  parameter int unsigned WIDTH = 16  // multiple of 4, at least 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo
`ifdef NIBBLE_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  a_q, b_q, diff_q;
  logic              bin_q, bo_q;
  logic              in_ready_q, out_valid_q;
  logic [3:0]        a_nib, b_nib, g, p, d, br;
  logic              last_nib;

  // Lookahead-borrow slice for the nibble selected by the counter.
  always_comb begin
    a_nib = a_q[{cnt_q, 2'b00} +: 4];
    b_nib = b_q[{cnt_q, 2'b00} +: 4];
    g     = ~a_nib & b_nib;
    p     = ~(a_nib ^ b_nib);
    d     = a_nib ^ b_nib ^ {br[2:0], bin_q};
    br[0] = g[0] | (p[0] & bin_q);
    br[1] = g[1] | (p[1] & br[0]);
    br[2] = g[2] | (p[2] & br[1]);
    br[3] = g[3] | (p[3] & br[2]);
  end

  assign last_nib = (cnt_q == CntW'(NIB - 1));

`ifdef NIBBLE_SUB_OVF_EN
  logic ovf_q;
  // Top bit of the result is d[3] of the last nibble, produced on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == StCalc && last_nib) begin
      ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ d[3]);
    end
  end
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      bin_q       <= 1'b0;
      diff_q      <= '0;
      bo_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a_in;
            b_q        <= b_in;
            bin_q      <= bi;
            cnt_q      <= '0;
            diff_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          diff_q[{cnt_q, 2'b00} +: 4] <= d;
          bin_q <= br[3];
          cnt_q <= cnt_q + CntW'(1);
          if (last_nib) begin
            bo_q        <= br[3];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bo        = bo_q;

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Scoreboard bench for nibble_sub_seq (WIDTH=16); ovf checks only when NIBBLE_SUB_OVF_EN is defined.
module tb_nibble_sub_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         bi = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bo;
`ifdef NIBBLE_SUB_OVF_EN
  logic         ovf;
`endif

  nibble_sub_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bo        (bo)
`ifdef NIBBLE_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial forever #5 clk = ~clk;

  // Expected entry: {ovf, bo, diff}
  typedef logic [W+1:0] exp_t;
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] full;
    logic       v;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
    v    = (a[W-1] ^ b[W-1]) & (a[W-1] ^ full[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  // An empty scoreboard yields X, which can never match a DUT value.
  function automatic exp_t pop_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1; a_in = a; b_in = b; bi = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(a, b, c));
  endtask

  // Edges counted from the acceptance edge until out_valid is seen.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (diff !== '0) $display("FAIL reset_diff: got %h want 0000", diff); else passed++;
    total++; if (bo !== 1'b0) $display("FAIL reset_bo: got %b want 0", bo); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int   lat;
    exp_t e;
    send(16'h1234, 16'h0234, 1'b0);
    wait_out(lat);
    e = pop_exp();
    total++; if (lat !== NIB) $display("FAIL basic_latency: got %0d want %0d", lat, NIB); else passed++;
    total++; if (diff !== e[W-1:0]) $display("FAIL basic_diff: got %h want %h", diff, e[W-1:0]); else passed++;
    total++; if (bo !== e[W]) $display("FAIL basic_bo: got %b want %b", bo, e[W]); else passed++;
    consume();
    total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL basic_ready_back: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_wrap();
    int   lat;
    exp_t e;
    send(16'h0000, 16'h0001, 1'b0);
    wait_out(lat);
    e = pop_exp();
    total++; if (lat !== NIB) $display("FAIL wrap_latency: got %0d want %0d", lat, NIB); else passed++;
    total++; if (diff !== e[W-1:0]) $display("FAIL wrap_diff: got %h want %h", diff, e[W-1:0]); else passed++;
    total++; if (bo !== e[W]) $display("FAIL wrap_bo: got %b want %b", bo, e[W]); else passed++;
    consume();
  endtask

  task automatic test_borrow_in();
    int   lat;
    exp_t e;
    send(16'h0005, 16'h0005, 1'b1);
    wait_out(lat);
    e = pop_exp();
    total++; if (diff !== e[W-1:0]) $display("FAIL bin1_diff: got %h want %h", diff, e[W-1:0]); else passed++;
    total++; if (bo !== e[W]) $display("FAIL bin1_bo: got %b want %b", bo, e[W]); else passed++;
    consume();
    send(16'hFFFF, 16'h0000, 1'b1);
    wait_out(lat);
    e = pop_exp();
    total++; if (diff !== e[W-1:0]) $display("FAIL bin2_diff: got %h want %h", diff, e[W-1:0]); else passed++;
    total++; if (bo !== e[W]) $display("FAIL bin2_bo: got %b want %b", bo, e[W]); else passed++;
    consume();
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    out_ready = 1'b0;
    send(16'hA5C3, 16'h5A3C, 1'b0);
    wait_out(lat);
    e = pop_exp();
    total++; if (lat !== NIB) $display("FAIL bp_latency: got %0d want %0d", lat, NIB); else passed++;
    in_valid = 1'b1; a_in = 16'h0100; b_in = 16'h0001; bi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); else passed++;
      total++; if (diff !== e[W-1:0]) $display("FAIL bp_hold_diff[%0d]: got %h want %h", i, diff, e[W-1:0]); else passed++;
      total++; if (bo !== e[W]) $display("FAIL bp_hold_bo[%0d]: got %b want %b", i, bo, e[W]); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, in_ready); else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else passed++;
    sb.push_back(model(16'h0100, 16'h0001, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    e = pop_exp();
    total++; if (lat !== NIB) $display("FAIL bp_next_latency: got %0d want %0d", lat, NIB); else passed++;
    total++; if (diff !== e[W-1:0]) $display("FAIL bp_next_diff: got %h want %h", diff, e[W-1:0]); else passed++;
    consume();
  endtask

  task automatic test_back_to_back();
    int     lat;
    exp_t   e;
    time    t_prev, t_now;
    for (int i = 0; i < 6; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      t_now = $time;
      if (i > 0) begin
        total++;
        if (t_now - t_prev !== (NIB + 2) * 10)
          $display("FAIL b2b_period[%0d]: got %0t want %0d", i, t_now - t_prev, (NIB + 2) * 10);
        else passed++;
      end
      t_prev = t_now;
      wait_out(lat);
      e = pop_exp();
      total++; if (diff !== e[W-1:0]) $display("FAIL b2b_diff[%0d]: got %h want %h", i, diff, e[W-1:0]); else passed++;
      total++; if (bo !== e[W]) $display("FAIL b2b_bo[%0d]: got %b want %b", i, bo, e[W]); else passed++;
      consume();
    end
  endtask

  task automatic test_reset_mid();
    int   lat;
    exp_t e;
    send(16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    total++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (diff !== '0) $display("FAIL rmid_diff: got %h want 0000", diff); else passed++;
    total++; if (bo !== 1'b0) $display("FAIL rmid_bo: got %b want 0", bo); else passed++;
    @(posedge clk); @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_no_pulse: got %b want 0", out_valid); else passed++;
    rst_n = 1'b1;
    send(16'h0010, 16'h0001, 1'b0);
    wait_out(lat);
    e = pop_exp();
    total++; if (lat !== NIB) $display("FAIL rmid_latency: got %0d want %0d", lat, NIB); else passed++;
    total++; if (diff !== e[W-1:0]) $display("FAIL rmid_diff_after: got %h want %h", diff, e[W-1:0]); else passed++;
    total++; if (bo !== e[W]) $display("FAIL rmid_bo_after: got %b want %b", bo, e[W]); else passed++;
    consume();
  endtask

`ifdef NIBBLE_SUB_OVF_EN
  task automatic test_ovf();
    int           lat;
    exp_t         e;
    logic [W-1:0] av [3] = '{16'h8000, 16'h7FFF, 16'h0003};
    logic [W-1:0] bv [3] = '{16'h0001, 16'hFFFF, 16'h0001};
    for (int i = 0; i < 3; i++) begin
      send(av[i], bv[i], 1'b0);
      wait_out(lat);
      e = pop_exp();
      total++; if (diff !== e[W-1:0]) $display("FAIL ovf_diff[%0d]: got %h want %h", i, diff, e[W-1:0]); else passed++;
      total++; if (bo !== e[W]) $display("FAIL ovf_bo[%0d]: got %b want %b", i, bo, e[W]); else passed++;
      total++; if (ovf !== e[W+1]) $display("FAIL ovf_flag[%0d]: got %b want %b", i, ovf, e[W+1]); else passed++;
      consume();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_borrow_in();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef NIBBLE_SUB_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
